// File: rtl/cache_mem_unit.sv
// Direct-mapped, write-back, write-allocate cache with one word per line and an internal miss sequencer.
// Hits complete two cycles after the request; misses insert write-back and refill handshakes on the mem_* port.
module cache_mem_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_is_byte,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_REFILL = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic              req_byte;
  logic [DATA_W-1:0] req_wdata;
  logic              first_lookup;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [OFF_W-1:0]  off;
  logic [OFF_W+2:0]  bit_ofs;
  logic [DATA_W-1:0] line;
  logic              hit;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_val;
  logic [ADDR_W-1:0] refill_addr;
  logic [ADDR_W-1:0] victim_addr;

  assign idx         = req_addr[OFF_W +: IDX_W];
  assign tag         = req_addr[ADDR_W-1 -: TAG_W];
  assign off         = req_addr[OFF_W-1:0];
  assign bit_ofs     = {off, 3'b000};
  assign line        = data_mem[idx];
  assign hit         = valid[idx] && (tag_mem[idx] == tag);
  assign refill_addr = {tag, idx, {OFF_W{1'b0}}};
  assign victim_addr = {tag_mem[idx], idx, {OFF_W{1'b0}}};

  always_comb begin
    merged = line;
    if (req_byte) merged[bit_ofs +: 8] = req_wdata[7:0];
    else          merged = req_wdata;
  end

  assign load_val = req_byte ? {{(DATA_W-8){1'b0}}, line[bit_ofs +: 8]} : line;

  // Line storage carries no reset; valid bits alone decide whether contents matter.
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && hit && req_we) data_mem[idx] <= merged;
    if (state == S_REFILL && mem_req && mem_ack) begin
      data_mem[idx] <= mem_rdata;
      tag_mem[idx]  <= tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req_addr     <= '0;
      req_we       <= 1'b0;
      req_byte     <= 1'b0;
      req_wdata    <= '0;
      first_lookup <= 1'b0;
      valid        <= '0;
      dirty        <= '0;
      cpu_ready    <= 1'b0;
      cpu_rdata    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            req_addr     <= cpu_addr;
            req_we       <= cpu_we;
            req_byte     <= cpu_is_byte;
            req_wdata    <= cpu_wdata;
            first_lookup <= 1'b1;
            state        <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          // The re-lookup after a refill is a guaranteed hit and stays out of the statistics.
          first_lookup <= 1'b0;
          if (first_lookup) begin
            if (hit) hit_cnt  <= hit_cnt + CNT_ONE;
            else     miss_cnt <= miss_cnt + CNT_ONE;
          end
          if (hit) begin
            if (req_we) dirty[idx] <= 1'b1;
            else        cpu_rdata  <= load_val;
            cpu_ready <= 1'b1;
            state     <= S_DONE;
          end else if (valid[idx] && dirty[idx]) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= victim_addr;
            mem_wdata <= line;
            state     <= S_WB;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= refill_addr;
            state    <= S_REFILL;
          end
        end
        S_WB: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            dirty[idx] <= 1'b0;
            state      <= S_REFILL;
          end
        end
        S_REFILL: begin
          // Arriving from write-back, mem_req is low for one cycle before the refill is issued.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= refill_addr;
          end else if (mem_ack) begin
            mem_req    <= 1'b0;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= S_LOOKUP;
          end
        end
        S_DONE: begin
          cpu_ready <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_unit.sv
// Bench for cache_mem_unit: directed scenarios then random traffic, checked against a flat-memory
// reference plus a tag-occupancy model that predicts hits, write-backs, refills and latency.
module tb_cache_mem_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_is_byte;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt, miss_cnt;

  cache_mem_unit #(.ADDR_W(32), .DATA_W(32), .LINES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_is_byte(cpu_is_byte),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] bmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          mvalid [16];
  bit          mdirty [16];
  logic [31:0] mtag   [16];
  int          exp_hit, exp_miss;

  int          wb_n, rf_n, unstable, lat;
  logic [31:0] wb_addr, wb_data, rf_addr, rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bm_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Drives one CPU request and plays the memory side with a fixed ack delay per transaction.
  task automatic bus_access(input logic we, input logic byt, input logic [31:0] a,
                            input logic [31:0] wd, input int dly);
    logic        held_we;
    logic [31:0] held_addr, held_wd;
    int          wc;
    bit          got;
    cpu_we = we; cpu_is_byte = byt; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0; wc = 0; got = 0;
    held_we = 1'b0; held_addr = '0; held_wd = '0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      mem_ack = 1'b0;
      if (cpu_ready) begin
        rd = cpu_rdata; cpu_req = 1'b0; got = 1;
      end else if (mem_req) begin
        if (wc == 0) begin
          held_we = mem_we; held_addr = mem_addr; held_wd = mem_wdata;
        end else if (mem_addr !== held_addr || mem_we !== held_we ||
                     (mem_we && mem_wdata !== held_wd)) begin
          unstable++;
        end
        if (wc >= dly) begin
          mem_ack = 1'b1; wc = 0;
          if (mem_we) begin
            bmem[mem_addr] = mem_wdata; wb_n++; wb_addr = mem_addr; wb_data = mem_wdata;
          end else begin
            mem_rdata = bm_rd(mem_addr); rf_n++; rf_addr = mem_addr;
          end
        end else begin
          wc++;
        end
      end
    end
    if (!got) begin
      cpu_req = 1'b0;
      rd = 'x;
    end
    check("cpu_ready_seen", got, 1'b1);
  endtask

  task automatic acc(input logic we, input logic byt, input logic [31:0] a,
                     input logic [31:0] wd, input int dly);
    int          idx, lane, w0, r0, exp_lat;
    logic [31:0] tg, wa, vict, vict_data, word, exp_rd;
    bit          hit, wb_exp;
    idx  = int'((a >> 2) & 32'hF);
    tg   = a >> 6;
    wa   = a & ~32'h3;
    lane = int'(a & 32'h3);
    hit    = mvalid[idx] && (mtag[idx] == tg);
    wb_exp = !hit && mvalid[idx] && mdirty[idx];
    vict      = (mtag[idx] << 6) | (idx << 2);
    vict_data = ref_rd(vict);
    word   = ref_rd(wa);
    exp_rd = byt ? {24'h0, word[lane*8 +: 8]} : word;
    exp_lat = hit ? 2 : (wb_exp ? 6 + 2*dly : 4 + dly);
    if (hit) exp_hit++; else exp_miss++;
    if (!hit) begin mvalid[idx] = 1; mtag[idx] = tg; mdirty[idx] = 0; end
    if (we) begin
      mdirty[idx] = 1;
      if (byt) word[lane*8 +: 8] = wd[7:0]; else word = wd;
      ref_mem[wa] = word;
    end
    w0 = wb_n; r0 = rf_n;
    bus_access(we, byt, a, wd, dly);
    check("latency", lat, exp_lat);
    check("hit_cnt", {16'h0, hit_cnt}, exp_hit);
    check("miss_cnt", {16'h0, miss_cnt}, exp_miss);
    check("wb_count", wb_n - w0, wb_exp ? 1 : 0);
    if (wb_exp) begin
      check("wb_addr", wb_addr, vict);
      check("wb_data", wb_data, vict_data);
    end
    check("refill_count", rf_n - r0, hit ? 0 : 1);
    if (!hit) check("refill_addr", rf_addr, wa & ~32'h3F | (a & 32'h3C));
    if (!we) check("load_data", rd, exp_rd);
    check("mem_stable", unstable, 0);
    @(posedge clk); #1;
    check("ready_one_cycle", cpu_ready, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = '0; end
    exp_hit = 0; exp_miss = 0;
    ref_mem = bmem;
  endtask

  initial begin
    bit          seen;
    logic [15:0] h0, m0;
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_is_byte = 0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ack = 0;
    wb_n = 0; rf_n = 0; unstable = 0; rd = '0; wb_addr = '0; wb_data = '0; rf_addr = '0;
    bmem[32'h40]  = 32'hDEADBEEF;
    bmem[32'h440] = 32'h12345678;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_hit_cnt", {16'h0, hit_cnt}, 32'h0);
    check("rst_miss_cnt", {16'h0, miss_cnt}, 32'h0);
    rst = 1'b0;

    acc(0, 0, 32'h40, 32'h0, 2);
    check("t1_refill_addr", rf_addr, 32'h40);
    check("t1_rdata", rd, 32'hDEADBEEF);
    acc(0, 0, 32'h40, 32'h0, 0);
    check("t2_hit_lat", lat, 2);
    acc(1, 1, 32'h41, 32'h000000AA, 0);
    acc(0, 0, 32'h40, 32'h0, 0);
    check("t3_merged_word", rd, 32'hDEADAAEF);
    acc(0, 1, 32'h41, 32'h0, 0);
    check("t3_byte_load", rd, 32'h000000AA);
    acc(0, 0, 32'h440, 32'h0, 1);
    check("t4_wb_addr", wb_addr, 32'h40);
    check("t4_wb_data", wb_data, 32'hDEADAAEF);
    check("t4_refill_addr", rf_addr, 32'h440);
    check("t4_rdata", rd, 32'h12345678);
    acc(0, 0, 32'h840, 32'h0, 10);
    check("t5_slow_refill_lat", lat, 14);

    // A stray ack while idle must not start or disturb anything.
    h0 = hit_cnt; m0 = miss_cnt;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray_ack_req", mem_req, 1'b0);
    check("stray_ack_ready", cpu_ready, 1'b0);
    check("stray_ack_cnt", {h0, m0}, {hit_cnt, miss_cnt});
    acc(0, 0, 32'h840, 32'h0, 0);

    acc(1, 0, 32'h840, 32'hCAFEF00D, 0);
    cpu_we = 0; cpu_is_byte = 0; cpu_addr = 32'h40; cpu_wdata = '0; cpu_req = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (mem_req && mem_we) seen = 1;
    end
    check("t6_wb_started", seen, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_mem_req", mem_req, 1'b0);
    check("t6_async_cpu_ready", cpu_ready, 1'b0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("t6_cnt_cleared", {hit_cnt, miss_cnt}, 32'h0);
    acc(0, 0, 32'h40, 32'h0, 0);
    check("t6_miss_after_rst", {16'h0, miss_cnt}, 32'h1);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2) |
          32'($urandom_range(0, 3));
      acc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
          int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
